// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI arbiter and the SPI byte engine it fronts.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitBusy,
    StWaitDone,
    StCapture,
    StNext
  } arb_state_t;

  localparam int unsigned WAIT_CNT_W    = 8;
  localparam int unsigned ENG_START_LAT = 2;  // engine start -> SPI_EN low, in clk cycles
  localparam bit          SPI_CPOL      = 1'b1;
  localparam bit          SPI_CPHA      = 1'b0;

  // Index width for an N-entry one-hot vector; never below 1 bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester-side bus of the SPI arbiter: per-requester byte handshake plus shared response.
interface spi_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   rsp_valid;
  logic [7:0]         rsp_data;
  logic [N_REQ-1:0]   gnt;
  logic               err;

  modport master (
    output req_valid, req_data, req_last,
    input  req_ready, rsp_valid, rsp_data, gnt, err
  );

  modport slave (
    input  req_valid, req_data, req_last,
    output req_ready, rsp_valid, rsp_data, gnt, err
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_pick
  import spi_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IdxW  = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             valid_o
);

  always_comb begin
    int unsigned cand;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr_i) + k) % N_REQ;
      if (!valid_o && req_i[IdxW'(cand)]) begin
        valid_o              = 1'b1;
        gnt_o[IdxW'(cand)]   = 1'b1;
        idx_o                = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin owner of one SPI byte engine: one engine start per byte, whole
// transactions per grant, received bytes routed back to the owner.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic         clk,
  input  logic         rst,
  spi_arbiter_if.slave bus_io,
  output logic         eng_start_o,
  output logic [7:0]   eng_data_o,
  input  logic         eng_en_i,
  input  logic [7:0]   eng_rx_i
);

  localparam int unsigned IdxW = idx_w(N_REQ);
  typedef logic [IdxW-1:0] idx_t;

  arb_state_t             state_q, state_d;
  logic [N_REQ-1:0]       gnt_q, gnt_d;
  idx_t                   own_q, own_d;
  idx_t                   ptr_q, ptr_d;
  logic                   last_q, last_d;
  logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [7:0]             rsp_data_q, rsp_data_d;
  logic                   err_q, err_d;

  logic [N_REQ-1:0]       pick_gnt;
  idx_t                   pick_idx;
  logic                   pick_any;
  idx_t                   ptr_after;
  logic                   wait_expired;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i   (bus_io.req_valid),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_any)
  );

  assign ptr_after    = (own_q == idx_t'(N_REQ - 1)) ? '0 : own_q + idx_t'(1);
  assign wait_expired = (cnt_q == WAIT_CNT_W'(WAIT_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      own_q       <= '0;
      ptr_q       <= '0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      own_q       <= own_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    own_d       = own_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    err_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A byte is never started while the engine still reports one in flight.
        if (pick_any && eng_en_i) begin
          gnt_d   = pick_gnt;
          own_d   = pick_idx;
          state_d = StStart;
        end
      end
      StStart: begin
        last_d  = bus_io.req_last[own_q];
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy, StWaitDone: begin
        if ((state_q == StWaitBusy) && !eng_en_i) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end else if ((state_q == StWaitDone) && eng_en_i) begin
          state_d = StCapture;
        end else if (wait_expired) begin
          err_d   = 1'b1;
          gnt_d   = '0;
          ptr_d   = ptr_after;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCapture: begin
        rsp_valid_d = gnt_q;
        rsp_data_d  = eng_rx_i;
        state_d     = StNext;
      end
      StNext: begin
        if (last_q) begin
          gnt_d   = '0;
          ptr_d   = ptr_after;
          state_d = StIdle;
        end else if (bus_io.req_valid[own_q] && eng_en_i) begin
          state_d = StStart;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    eng_start_o      = (state_q == StStart);
    eng_data_o       = eng_start_o ? bus_io.req_data[{own_q, 3'b000} +: 8] : 8'h00;
    bus_io.req_ready = eng_start_o ? gnt_q : '0;
    bus_io.rsp_valid = rsp_valid_q;
    bus_io.rsp_data  = rsp_data_q;
    bus_io.gnt       = gnt_q;
    bus_io.err       = err_q;
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter with a behavioural SPI byte engine that replies tx ^ 0x99.
module tb_spi_arbiter;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       eng_start;
  logic [7:0] eng_data;
  logic       eng_en;
  logic [7:0] eng_rx;

  spi_arbiter_if #(.N_REQ(N)) bus ();

  spi_arbiter #(
    .N_REQ      (N),
    .WAIT_LIMIT (255)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_io      (bus),
    .eng_start_o (eng_start),
    .eng_data_o  (eng_data),
    .eng_en_i    (eng_en),
    .eng_rx_i    (eng_rx)
  );

  always #5 clk = ~clk;

  // Engine model: EN low two cycles after start, high again 8 cycles later,
  // data_out updated the cycle after EN rises. Hang mode ignores starts.
  bit         eng_hang = 1'b0;
  int         eng_cnt;
  logic [7:0] eng_tx;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_en  <= 1'b1;
      eng_cnt <= 0;
      eng_rx  <= 8'h00;
      eng_tx  <= 8'h00;
    end else if (eng_cnt == 0) begin
      if (eng_start && !eng_hang) begin
        eng_cnt <= 1;
        eng_tx  <= eng_data;
      end
    end else begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == 1) eng_en <= 1'b0;
      if (eng_cnt == 9) eng_en <= 1'b1;
      if (eng_cnt == 10) begin
        eng_rx  <= eng_tx ^ 8'h99;
        eng_cnt <= 0;
      end
    end
  end

  typedef struct packed {logic [7:0] d; logic l;} txb_t;
  typedef struct packed {logic [3:0] v; logic [7:0] d;} rsp_t;

  txb_t       txq[N][$];
  rsp_t       exp_rsp[$];
  logic [3:0] exp_gnt[$];
  logic [7:0] exp_tx[$];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int start_cnt = 0;
  int starts_by[N];
  int start_time = 0;
  int err_time = 0;
  int err_seen = 0;
  logic [3:0] prev_gnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic push(input int r, input logic [7:0] d, input bit l, input bit rsp);
    txq[r].push_back({d, l});
    exp_tx.push_back(d);
    if (rsp) exp_rsp.push_back({4'(1 << r), d ^ 8'h99});
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      done = (bus.gnt == '0) && (txq[0].size() == 0) && (txq[1].size() == 0) &&
             (txq[2].size() == 0) && (txq[3].size() == 0) && (exp_rsp.size() == 0) &&
             (exp_gnt.size() == 0) && (exp_tx.size() == 0);
    end
    if (!done) begin
      checks++;
      $display("FAIL %s: got timeout expected idle within %0d cycles", name, max_cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Requester drivers: present queue head, pop one cycle after the accepting START.
  bit [N-1:0] popf = '0;
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        if (popf[r]) begin
          void'(txq[r].pop_front());
          popf[r] = 1'b0;
        end
        if (txq[r].size() > 0) begin
          bus.req_valid[r]        = 1'b1;
          bus.req_data[8*r +: 8]  = txq[r][0].d;
          bus.req_last[r]         = txq[r][0].l;
        end else begin
          bus.req_valid[r] = 1'b0;
        end
        if (bus.req_valid[r] && bus.req_ready[r]) popf[r] = 1'b1;
      end
    end
  end

  // Monitor: compare every grant, engine start and response against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.gnt != '0 && prev_gnt == '0) begin
        if (exp_gnt.size() == 0) fail("grant_unexpected");
        else chk("grant", 32'(bus.gnt), 32'(exp_gnt.pop_front()));
      end
      if (eng_start) begin
        start_cnt++;
        start_time = cyc;
        for (int r = 0; r < N; r++) if (bus.gnt[r]) starts_by[r]++;
        chk("start_while_en_high", 32'(eng_en), 32'd1);
        if (exp_tx.size() == 0) fail("eng_start_unexpected");
        else chk("eng_data", 32'(eng_data), 32'(exp_tx.pop_front()));
      end
      if (bus.rsp_valid != '0) begin
        rsp_t e;
        if (exp_rsp.size() == 0) fail("rsp_unexpected");
        else begin
          e = exp_rsp.pop_front();
          chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.v));
          chk("rsp_data", 32'(bus.rsp_data), 32'(e.d));
        end
      end
      if (bus.err) begin
        err_seen++;
        err_time = cyc;
      end
    end
    prev_gnt = bus.gnt;
  end

  initial begin
    int s0;
    int bad;
    bit seen;
    for (int r = 0; r < N; r++) starts_by[r] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_eng_start", 32'(eng_start), 0);
    chk("rst_eng_data", 32'(eng_data), 0);
    rst = 1'b0;

    // Single byte from requester 1: A5 -> 3C; pointer moves to 2
    exp_gnt.push_back(4'b0010);
    push(1, 8'hA5, 1'b1, 1'b1);
    wait_idle("t1_single", 200);
    chk("t1_starts_req1", 32'(starts_by[1]), 1);

    // Pointer at 2: requester 3 beats requester 0
    exp_gnt.push_back(4'b1000);
    exp_gnt.push_back(4'b0001);
    push(3, 8'h33, 1'b1, 1'b1);
    push(0, 8'h30, 1'b1, 1'b1);
    wait_idle("t1b_pointer", 300);

    // Three-byte transaction from 0; requester 2 arrives during byte 1 and must wait
    s0 = starts_by[0];
    exp_gnt.push_back(4'b0001);
    exp_gnt.push_back(4'b0100);
    push(0, 8'h01, 1'b0, 1'b1);
    push(0, 8'h02, 1'b0, 1'b1);
    push(0, 8'h03, 1'b1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = (bus.gnt == 4'b0001);
    end
    chk("t2_owner0_granted", 32'(seen), 1);
    push(2, 8'h55, 1'b1, 1'b1);
    wait_idle("t2_multi", 400);
    chk("t2_starts_req0", 32'(starts_by[0] - s0), 3);

    // All four requesting continuously; pointer at 3 -> 3,0,1,2,3,0,1,2
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) begin
        int r;
        r = (j + 3) % 4;
        exp_gnt.push_back(4'(1 << r));
        push(r, 8'(8'h10 + 16 * k + r), 1'b1, 1'b1);
      end
    end
    wait_idle("t3_all", 800);

    // Owner pauses 20 cycles mid-transaction: grant held, no starts
    exp_gnt.push_back(4'b0010);
    push(1, 8'h40, 1'b0, 1'b1);
    for (int i = 0; i < 100 && exp_rsp.size() != 0; i++) @(negedge clk);
    chk("t4_first_rsp", 32'(exp_rsp.size()), 0);
    s0 = start_cnt;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.gnt != 4'b0010) bad++;
    end
    chk("t4_gnt_held", 32'(bad), 0);
    chk("t4_no_start", 32'(start_cnt - s0), 0);
    push(1, 8'h41, 1'b1, 1'b1);
    wait_idle("t4_resume", 200);

    // Engine hangs: abort after the wait limit, no response, then normal service
    eng_hang = 1'b1;
    exp_gnt.push_back(4'b1000);
    push(3, 8'h77, 1'b1, 1'b0);
    for (int i = 0; i < 600 && err_seen == 0; i++) @(negedge clk);
    chk("t5_err_seen", 32'(err_seen), 1);
    chk("t5_err_latency", 32'(err_time - start_time), 257);
    chk("t5_gnt_released", 32'(bus.gnt), 0);
    eng_hang = 1'b0;
    exp_gnt.push_back(4'b0100);
    push(2, 8'h5A, 1'b1, 1'b1);
    wait_idle("t5_recover", 200);

    // Reset while waiting for the byte to finish
    exp_gnt.push_back(4'b0001);
    push(0, 8'h11, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = !eng_en;
    end
    chk("t6_in_flight", 32'(seen), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_gnt", 32'(bus.gnt), 0);
    chk("t6_rst_req_ready", 32'(bus.req_ready), 0);
    chk("t6_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("t6_rst_err", 32'(bus.err), 0);
    chk("t6_rst_eng_start", 32'(eng_start), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_gnt.push_back(4'b0001);
    exp_gnt.push_back(4'b1000);
    push(0, 8'h60, 1'b1, 1'b1);
    push(3, 8'h63, 1'b1, 1'b1);
    wait_idle("t6_after_reset", 300);

    chk("end_rsp_left", 32'(exp_rsp.size()), 0);
    chk("end_tx_left", 32'(exp_tx.size()), 0);
    chk("end_err_total", 32'(err_seen), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Round-robin arbiter and byte sequencer that shares one SPI byte engine (SPI_driver, mode CPOL=1/CPHA=0, active-low SPI_EN) among N requesters.
- A requester owns the engine for a whole transaction: one or more bytes, terminated by a byte flagged last. The arbiter issues one engine start per byte and detects completion from the engine's SPI_EN.
- It routes each received byte back to the owning requester.
- It sits between the client blocks (flash reader, sensor poller, config writer) and the single SPI_driver instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WAIT_LIMIT, 255, max clk cycles allowed in either engine-wait state before error abort (8-bit counter range).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  N_REQ  per-requester: tx byte available
- req_data  in  8*N_REQ  per-requester tx byte; requester i uses bits [8i+7:8i]
- req_last  in  N_REQ  per-requester: current byte ends the transaction
- req_ready  out  N_REQ  one-hot: tx byte accepted this cycle
- rsp_valid  out  N_REQ  one-hot pulse: rsp_data is valid for this requester
- rsp_data  out  8  received byte, shared bus
- gnt  out  N_REQ  one-hot current owner, 0 when idle
- err  out  1  one-cycle pulse on timeout abort
- eng_start  out  1  to SPI_driver SPI_start
- eng_data  out  8  to SPI_driver data_in
- eng_en  in  1  from SPI_driver SPI_EN (low = byte in flight)
- eng_rx  in  8  from SPI_driver data_out

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, gnt=0, err=0, eng_start=0, eng_data=0. The round-robin pointer resets to 0 (requester 0 has highest priority first). Reset mid-transaction returns to IDLE immediately; the engine is not notified.
- State machine: IDLE, START, WAIT_BUSY, WAIT_DONE, CAPTURE, NEXT.
- IDLE:
  - Choose the first i with req_valid[i], searching from pointer upward with wrap.
  - Register gnt=onehot(i) and go to START. If none, stay.
- START:
  - Registered outputs: eng_start=1 and eng_data=req_data[i] for exactly one cycle.
  - req_ready[i]=1 in the same cycle. Latch req_last[i] into last_q.
  - Go to WAIT_BUSY.
- WAIT_BUSY: wait for eng_en==0 (the engine asserts it 2 cycles after start), then go to WAIT_DONE.
- WAIT_DONE: wait for eng_en==1, then go to CAPTURE.
- CAPTURE:
  - One wait cycle, because the engine updates data_out the cycle after SPI_EN rises.
  - On the following cycle, rsp_data=eng_rx and rsp_valid[i]=1 (one cycle). Go to NEXT.
- NEXT:
  - If last_q: gnt=0, pointer=i+1 mod N_REQ, go to IDLE.
  - Else if req_valid[i]: go to START.
  - Else stay in NEXT, still owning the engine. Other requesters cannot preempt.
- Wait counter:
  - Cleared on entry to WAIT_BUSY and WAIT_DONE; increments each cycle in those states.
  - On reaching WAIT_LIMIT: err pulse, rsp_valid not asserted, gnt=0, pointer advances, go to IDLE.
- eng_start is asserted only in START. The arbiter never starts a byte while eng_en==0.
- Simultaneous requests: resolved purely by pointer order. A requester deasserting req_valid before START loses nothing. Requesters must hold req_data/req_last stable while req_valid is high.
- Single-byte transaction: START→…→NEXT→IDLE. Byte-to-byte gap inside a transaction is fixed by the state walk: NEXT→START adds 1 cycle.
- N_REQ=1: pointer is constant 0.

Decomposition:
- Package spi_pkg: state enum arb_state_t, WAIT_CNT_W=8, the engine start-to-EN-low latency constant (2), and the SPI mode constants (CPOL=1, CPHA=0) shared with SPI_driver.
- One sub-module, rr_pick: combinational round-robin picker with inputs req vector and pointer, and output one-hot grant plus index. It is reused by other shared-resource arbiters.

Test Plan:
- Single requester 1, one byte 0xA5 with last. Engine model returns 0x3C → eng_data=0xA5, one eng_start pulse; rsp_valid[1] with rsp_data=0x3C; gnt back to 0; pointer=2.
- Requester 0 sends a 3-byte transaction 0x01,0x02,0x03. Requester 2 raises req_valid during byte 1 → requester 2 is not granted until after the third rsp_valid[0]. Exactly 3 eng_start pulses for requester 0.
- All 4 requesters hold single-byte last requests continuously → grant order 0,1,2,3,0. No requester is granted twice in a row.
- Owner deasserts req_valid for 20 cycles mid-transaction → arbiter stays in NEXT, gnt held, no eng_start. Transaction resumes when req_valid returns.
- Engine model holds eng_en high forever after start → err pulse after WAIT_LIMIT=255 cycles in WAIT_BUSY; no rsp_valid; gnt=0; next request is served normally.
- Assert rst while in WAIT_DONE → all outputs return to 0 immediately (asynchronously). After release, requester 0 has first priority.
